// File: rtl/mipi_cam_tx.sv
// Camera nibble-stream transmitter: FS, per line {LS, pixels, LE, blank}, FE framing of RGB565 pixels.
// Latency: first FS nibble one cycle after START in IDLE; pixel reads lead their MS nibble by two cycles.
// Backpressure: none; the stream runs at one nibble per clock, and START is ignored while a frame is in flight.
module mipi_cam_tx #(
  parameter int CAM_DATA_WIDTH = 4,
  parameter int H_PIXELS       = 640,
  parameter int V_LINES        = 480,
  parameter int H_BLANK        = 16
) (
  input  logic                      CAM_CLK,
  input  logic                      RESET,
  input  logic                      START,
  output logic                      PIX_RD,
  output logic [9:0]                PIX_ADDR,
  output logic [8:0]                PIX_LINE,
  input  logic [15:0]               PIX_DATA,
  output logic [CAM_DATA_WIDTH-1:0] CAM_DATA,
  output logic                      BUSY,
  output logic                      FRAME_DONE
);

  localparam logic [9:0] H_LAST = 10'(H_PIXELS - 1);
  localparam logic [8:0] V_LAST = 9'(V_LINES - 1);
  localparam logic [7:0] B_LAST = 8'(H_BLANK - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FS     = 3'd1,
    LS     = 3'd2,
    ACTIVE = 3'd3,
    LE     = 3'd4,
    HBLANK = 3'd5,
    FE     = 3'd6
  } state_t;

  // state and counters describe the nibble currently on CAM_DATA
  state_t      state, state_nxt;
  logic [1:0]  nib, nib_nxt;
  logic [9:0]  pix, pix_nxt;
  logic [8:0]  line, line_nxt;
  logic [7:0]  blank, blank_nxt;
  logic [15:0] pix_word, pix_word_nxt;

  logic [3:0]  data_nxt;
  logic        rd_nxt;
  logic [9:0]  addr_nxt;
  logic [8:0]  line_out_nxt;
  logic        busy_nxt;
  logic        done_nxt;

  // pixel nibbles never carry 0xF, so a sync code cannot appear inside pixel data
  function automatic logic [3:0] scrub(input logic [3:0] n);
    return (n == 4'hF) ? 4'hE : n;
  endfunction

  // sync codes are F,0,0,code
  function automatic logic [3:0] sync_nib(input logic [1:0] i, input logic [3:0] code);
    logic [3:0] r;
    case (i)
      2'd0:    r = 4'hF;
      2'd3:    r = code;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // next stream position, and the registered outputs that belong to it
  always_comb begin
    state_nxt    = state;
    nib_nxt      = nib;
    pix_nxt      = pix;
    line_nxt     = line;
    blank_nxt    = blank;
    pix_word_nxt = pix_word;
    data_nxt     = 4'h0;
    rd_nxt       = 1'b0;
    addr_nxt     = PIX_ADDR;
    line_out_nxt = PIX_LINE;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = FS;
          nib_nxt   = 2'd0;
        end
      end
      FS: begin
        if (nib != 2'd3) begin
          nib_nxt = nib + 2'd1;
        end else begin
          state_nxt = LS;
          nib_nxt   = 2'd0;
          line_nxt  = 9'd0;
        end
      end
      LS: begin
        if (nib != 2'd3) begin
          nib_nxt = nib + 2'd1;
        end else begin
          state_nxt = ACTIVE;
          nib_nxt   = 2'd0;
          pix_nxt   = 10'd0;
        end
      end
      ACTIVE: begin
        if (nib != 2'd3) begin
          nib_nxt = nib + 2'd1;
        end else if (pix != H_LAST) begin
          nib_nxt = 2'd0;
          pix_nxt = pix + 10'd1;
        end else begin
          state_nxt = LE;
          nib_nxt   = 2'd0;
        end
      end
      LE: begin
        if (nib != 2'd3) begin
          nib_nxt = nib + 2'd1;
        end else begin
          state_nxt = HBLANK;
          blank_nxt = 8'd0;
        end
      end
      HBLANK: begin
        if (blank != B_LAST) begin
          blank_nxt = blank + 8'd1;
        end else if (line != V_LAST) begin
          state_nxt = LS;
          nib_nxt   = 2'd0;
          line_nxt  = line + 9'd1;
        end else begin
          state_nxt = FE;
          nib_nxt   = 2'd0;
        end
      end
      FE: begin
        if (nib != 2'd3) begin
          nib_nxt = nib + 2'd1;
        end else begin
          state_nxt = IDLE;
          nib_nxt   = 2'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        nib_nxt   = 2'd0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);

    case (state_nxt)
      FS: data_nxt = sync_nib(nib_nxt, 4'h8);
      LS: begin
        data_nxt = sync_nib(nib_nxt, 4'h9);
        // first pixel of the line is fetched two nibbles ahead of its MS nibble
        if (nib_nxt == 2'd2) begin
          rd_nxt       = 1'b1;
          addr_nxt     = 10'd0;
          line_out_nxt = line_nxt;
        end
      end
      ACTIVE: begin
        case (nib_nxt)
          2'd0: begin
            // RAM data is valid now, one cycle after the read strobe
            data_nxt     = scrub(PIX_DATA[15:12]);
            pix_word_nxt = PIX_DATA;
          end
          2'd1: data_nxt = scrub(pix_word[11:8]);
          2'd2: begin
            data_nxt = scrub(pix_word[7:4]);
            if (pix_nxt != H_LAST) begin
              rd_nxt       = 1'b1;
              addr_nxt     = pix_nxt + 10'd1;
              line_out_nxt = line_nxt;
            end
          end
          default: data_nxt = scrub(pix_word[3:0]);
        endcase
      end
      LE: data_nxt = sync_nib(nib_nxt, 4'hA);
      FE: begin
        data_nxt = sync_nib(nib_nxt, 4'hB);
        done_nxt = (nib_nxt == 2'd3);
      end
      default: data_nxt = 4'h0;
    endcase
  end

  // state and counter registers
  always_ff @(posedge CAM_CLK) begin
    if (RESET) begin
      state    <= IDLE;
      nib      <= 2'd0;
      pix      <= 10'd0;
      line     <= 9'd0;
      blank    <= 8'd0;
      pix_word <= 16'h0000;
    end else begin
      state    <= state_nxt;
      nib      <= nib_nxt;
      pix      <= pix_nxt;
      line     <= line_nxt;
      blank    <= blank_nxt;
      pix_word <= pix_word_nxt;
    end
  end

  // registered stream and RAM-side outputs
  always_ff @(posedge CAM_CLK) begin
    if (RESET) begin
      CAM_DATA   <= '0;
      PIX_RD     <= 1'b0;
      PIX_ADDR   <= 10'd0;
      PIX_LINE   <= 9'd0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      CAM_DATA   <= CAM_DATA_WIDTH'(data_nxt);
      PIX_RD     <= rd_nxt;
      PIX_ADDR   <= addr_nxt;
      PIX_LINE   <= line_out_nxt;
      BUSY       <= busy_nxt;
      FRAME_DONE <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mipi_cam_tx.sv
// Scoreboard bench for mipi_cam_tx with a 4-pixel, 2-line, 2-blank frame (60 nibbles).
// Stimulus pushes expected nibbles and pixel reads; a negedge monitor pops and compares.
// The pixel RAM model returns data one cycle after PIX_RD.
module tb_mipi_cam_tx;

  localparam int HP = 4;
  localparam int VL = 2;
  localparam int HB = 2;
  localparam int FRAME_LEN = 8 + VL * (8 + 4 * HP + HB);

  logic        CAM_CLK;
  logic        RESET;
  logic        START;
  logic        PIX_RD;
  logic [9:0]  PIX_ADDR;
  logic [8:0]  PIX_LINE;
  logic [15:0] PIX_DATA;
  logic [3:0]  CAM_DATA;
  logic        BUSY;
  logic        FRAME_DONE;

  mipi_cam_tx #(
    .CAM_DATA_WIDTH(4),
    .H_PIXELS(HP),
    .V_LINES(VL),
    .H_BLANK(HB)
  ) dut (
    .CAM_CLK(CAM_CLK),
    .RESET(RESET),
    .START(START),
    .PIX_RD(PIX_RD),
    .PIX_ADDR(PIX_ADDR),
    .PIX_LINE(PIX_LINE),
    .PIX_DATA(PIX_DATA),
    .CAM_DATA(CAM_DATA),
    .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE)
  );

  initial CAM_CLK = 1'b0;
  always #5 CAM_CLK = ~CAM_CLK;

  typedef struct packed {
    logic [3:0] n;
    logic       ms;
    logic       done;
    logic       gap;
  } exp_t;

  typedef struct packed {
    logic [8:0] line;
    logic [9:0] addr;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   due_q[$];

  logic [15:0] ram [0:VL-1][0:HP-1];

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int busy_run = 0;
  int last_done = 0;
  bit mon_en = 1'b0;

  int gen_idx;
  int gen_keep;
  bit gen_gap;

  always @(posedge CAM_CLK) cyc <= cyc + 1;

  // pixel source RAM: one-cycle read latency
  initial PIX_DATA = 16'h0000;
  always @(posedge CAM_CLK) if (PIX_RD === 1'b1) PIX_DATA <= ram[PIX_LINE[0]][PIX_ADDR[1:0]];

  task automatic check(input bit ok, input string name, input int act, input int req);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [3:0] pixnib(input logic [3:0] n);
    return (n == 4'hF) ? 4'hE : n;
  endfunction

  task automatic put_nib(input logic [3:0] n, input bit ms, input bit done);
    if (gen_idx < gen_keep) exp_q.push_back(exp_t'{n, ms, done, (gen_gap && gen_idx == 0)});
    gen_idx++;
  endtask

  // a read is expected during the nibble that will be pushed next
  task automatic put_rd(input int l, input int a);
    if (gen_idx < gen_keep) rd_q.push_back(rd_t'{9'(l), 10'(a)});
  endtask

  task automatic push_frame(input int keep, input bit gap);
    logic [15:0] w;
    gen_idx  = 0;
    gen_keep = keep;
    gen_gap  = gap;
    put_nib(4'hF, 0, 0); put_nib(4'h0, 0, 0); put_nib(4'h0, 0, 0); put_nib(4'h8, 0, 0);
    for (int l = 0; l < VL; l++) begin
      put_nib(4'hF, 0, 0); put_nib(4'h0, 0, 0);
      put_rd(l, 0);
      put_nib(4'h0, 0, 0); put_nib(4'h9, 0, 0);
      for (int p = 0; p < HP; p++) begin
        w = ram[l][p];
        put_nib(pixnib(w[15:12]), 1, 0);
        put_nib(pixnib(w[11:8]), 0, 0);
        if (p < HP - 1) put_rd(l, p + 1);
        put_nib(pixnib(w[7:4]), 0, 0);
        put_nib(pixnib(w[3:0]), 0, 0);
      end
      put_nib(4'hF, 0, 0); put_nib(4'h0, 0, 0); put_nib(4'h0, 0, 0); put_nib(4'hA, 0, 0);
      for (int b = 0; b < HB; b++) put_nib(4'h0, 0, 0);
    end
    put_nib(4'hF, 0, 0); put_nib(4'h0, 0, 0); put_nib(4'h0, 0, 0); put_nib(4'hB, 0, 1);
  endtask

  // monitor: pops expectations whenever the DUT presents a read or a nibble
  always @(negedge CAM_CLK) begin
    if (mon_en) begin
      if (PIX_RD) begin
        if (rd_q.size() == 0) begin
          check(1'b0, "rd_unexpected", int'(PIX_ADDR), 0);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          check(PIX_ADDR == r.addr, "rd_addr", int'(PIX_ADDR), int'(r.addr));
          check(PIX_LINE == r.line, "rd_line", int'(PIX_LINE), int'(r.line));
        end
        due_q.push_back(cyc + 2);
      end
      if (BUSY) begin
        busy_run++;
        if (exp_q.size() == 0) begin
          check(1'b0, "busy_unexpected", int'(CAM_DATA), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(CAM_DATA == e.n, "cam_data", int'(CAM_DATA), int'(e.n));
          check(FRAME_DONE == e.done, "frame_done", int'(FRAME_DONE), int'(e.done));
          if (e.ms) begin
            if (due_q.size() == 0) check(1'b0, "rd_missing", cyc, 0);
            else begin
              int d;
              d = due_q.pop_front();
              check(d == cyc, "rd_lead", cyc, d);
            end
          end
          if (e.gap) check(cyc - last_done == 2, "b2b_gap", cyc - last_done, 2);
          if (e.done) begin
            check(busy_run == FRAME_LEN, "busy_len", busy_run, FRAME_LEN);
            last_done = cyc;
          end
        end
      end else begin
        busy_run = 0;
        check(CAM_DATA == 4'h0, "idle_data", int'(CAM_DATA), 0);
        check(FRAME_DONE == 1'b0, "idle_done", int'(FRAME_DONE), 0);
      end
    end
  end

  task automatic pulse_start();
    @(posedge CAM_CLK); #1 START = 1'b1;
    @(posedge CAM_CLK); #1 START = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CAM_CLK); #1;
      if (exp_q.size() == 0 && !BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, name, exp_q.size(), 0);
    repeat (4) @(posedge CAM_CLK);
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b1;
    for (int l = 0; l < VL; l++)
      for (int p = 0; p < HP; p++) ram[l][p] = 16'h1234;

    // reset state, with START held during reset
    repeat (3) @(posedge CAM_CLK);
    @(negedge CAM_CLK);
    check(CAM_DATA == 4'h0, "rst_cam_data", int'(CAM_DATA), 0);
    check(PIX_RD == 1'b0, "rst_pix_rd", int'(PIX_RD), 0);
    check(PIX_ADDR == 10'd0, "rst_pix_addr", int'(PIX_ADDR), 0);
    check(PIX_LINE == 9'd0, "rst_pix_line", int'(PIX_LINE), 0);
    check(BUSY == 1'b0, "rst_busy", int'(BUSY), 0);
    check(FRAME_DONE == 1'b0, "rst_frame_done", int'(FRAME_DONE), 0);
    @(posedge CAM_CLK); #1;
    RESET = 1'b0;
    START = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge CAM_CLK);

    // frame of constant 0x1234 pixels
    push_frame(FRAME_LEN, 1'b0);
    pulse_start();
    wait_idle(200, "frame1_timeout");

    // distinct pixels incl. 0xF nibbles; START pulses mid-frame and on the last FE nibble
    ram[0][0] = 16'hF0FF; ram[0][1] = 16'hABCD; ram[0][2] = 16'h5F6F; ram[0][3] = 16'h0123;
    ram[1][0] = 16'hFFFF; ram[1][1] = 16'h8421; ram[1][2] = 16'h1E2F; ram[1][3] = 16'h7654;
    push_frame(FRAME_LEN, 1'b0);
    pulse_start();
    repeat (9) @(posedge CAM_CLK);
    #1 START = 1'b1;
    @(posedge CAM_CLK); #1 START = 1'b0;
    repeat (48) @(posedge CAM_CLK);
    #1 START = 1'b1;
    @(posedge CAM_CLK); #1 START = 1'b0;
    wait_idle(200, "frame2_timeout");

    // reset during nibble 30 aborts the frame; START during reset is ignored
    push_frame(31, 1'b0);
    @(posedge CAM_CLK); #1 START = 1'b1;
    @(posedge CAM_CLK); #1 START = 1'b0;
    repeat (30) @(posedge CAM_CLK);
    #1 RESET = 1'b1; START = 1'b1;
    @(posedge CAM_CLK); #1 RESET = 1'b0; START = 1'b0;
    @(negedge CAM_CLK); #1;
    check(CAM_DATA == 4'h0, "abort_cam_data", int'(CAM_DATA), 0);
    check(BUSY == 1'b0, "abort_busy", int'(BUSY), 0);
    check(FRAME_DONE == 1'b0, "abort_done", int'(FRAME_DONE), 0);
    check(PIX_ADDR == 10'd0, "abort_pix_addr", int'(PIX_ADDR), 0);
    check(exp_q.size() == 0, "abort_nibbles", exp_q.size(), 0);
    repeat (10) @(posedge CAM_CLK);
    check(due_q.size() == 0, "abort_due", due_q.size(), 0);
    push_frame(FRAME_LEN, 1'b0);
    pulse_start();
    wait_idle(200, "frame_after_abort_timeout");

    // START held high: three back-to-back frames, each FS two cycles after previous FE
    push_frame(FRAME_LEN, 1'b0);
    push_frame(FRAME_LEN, 1'b1);
    push_frame(FRAME_LEN, 1'b1);
    @(posedge CAM_CLK); #1 START = 1'b1;
    repeat (130) @(posedge CAM_CLK);
    #1 START = 1'b0;
    wait_idle(300, "b2b_timeout");

    repeat (10) @(posedge CAM_CLK);
    @(negedge CAM_CLK); #1;
    check(rd_q.size() == 0, "reads_left", rd_q.size(), 0);
    check(due_q.size() == 0, "due_left", due_q.size(), 0);
    check(BUSY == 1'b0, "final_busy", int'(BUSY), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
